// File: rtl/next_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_unit_if
// Purpose  : Groups the signals between the fetch control logic and
//            next_pc_unit: the PC fed back from the PC register, the
//            flow-control requests, and the next-address and status outputs.
// Ports    : master - drives pc and the control requests, receives next_pc
//                     and the status flags (CPU side / testbench)
//            slave  - next_pc_unit side
// Revision : 1.0 - initial release
// ============================================================================
interface next_pc_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] pc;
  logic             stall;
  logic             halt_req;
  logic             resume;
  logic             branch;
  logic [WIDTH-1:0] branch_off;
  logic             jump;
  logic [WIDTH-1:0] target;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] next_pc;
  logic             halted;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_err;

  modport master (
    output pc, stall, halt_req, resume, branch, branch_off,
           jump, target, call, ret,
    input  next_pc, halted, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  pc, stall, halt_req, resume, branch, branch_off,
           jump, target, call, ret,
    output next_pc, halted, ras_empty, ras_full, ras_err
  );
endinterface
`default_nettype wire

// File: rtl/next_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_unit
// Purpose  : Next-address stage feeding the loadless PC register. Selects
//            among hold, sequential increment, PC-relative branch, absolute
//            jump and call/return; a BOOT/RUN/HALT state machine handles
//            start-up, halt and resume. All state changes on the falling
//            clock edge, the same edge on which the PC register captures.
// Ports    : clk, rst        - falling-edge clock, async active-high reset
//            bus (slave)     - pc/stall/halt_req/resume/branch/branch_off/
//                              jump/target/call/ret in; next_pc
//                              (combinational), halted, ras_empty, ras_full,
//                              ras_err (registered) out
// Config   : NEXT_PC_RAS_EN  - when defined, builds the return-address
//                              stack; otherwise call/ret act as jumps and
//                              the stack flags are tied off.
// Revision : 1.0 - initial release
// ============================================================================
module next_pc_unit #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               RAS_DEPTH = 4
) (
  input wire            clk,
  input wire            rst,
  next_pc_unit_if.slave bus
);

  // Stack indexing relies on pointer wrap-around, so the depth must be a
  // power of two.
  if ((RAS_DEPTH < 2) || (RAS_DEPTH > 8) ||
      ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_ras_depth
    $error("next_pc_unit: RAS_DEPTH must be a power of two in 2..8");
  end

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_halted;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_branch_tgt;

  // Modulo-2^WIDTH arithmetic: carries out of the top bit are dropped.
  assign w_pc_inc     = bus.pc + WIDTH'(1);
  assign w_branch_tgt = w_pc_inc + bus.branch_off;

`ifdef NEXT_PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] C_CNT_FULL = CW'(RAS_DEPTH);

  // r_ptr addresses the next free slot; the top of stack is r_ptr-1.
  // When the stack is full r_ptr therefore lands on the oldest entry,
  // which is exactly the one a push must overwrite.
  logic [WIDTH-1:0] r_stack [RAS_DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ras_empty;
  logic             r_ras_full;
  logic             r_ras_err;

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_cnt_zero;
  logic             w_cnt_full;
  logic [PW-1:0]    w_ptr_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_err_set;

  assign w_ras_top  = r_stack[r_ptr - PW'(1)];
  assign w_cnt_zero = (r_count == '0);
  assign w_cnt_full = (r_count == C_CNT_FULL);
`endif

  // --------------------------------------------------------------------------
  // Next-address selection and next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_pc   = bus.pc;
    w_state_nxt = r_state;
`ifdef NEXT_PC_RAS_EN
    w_push      = 1'b0;
    w_pop       = 1'b0;
`endif
    case (r_state)
      ST_BOOT: begin
        w_next_pc   = RESET_PC;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.stall) begin
          w_next_pc = bus.pc;
        end else if (bus.halt_req) begin
          w_next_pc   = bus.pc;
          w_state_nxt = ST_HALT;
        end else if (bus.ret) begin
          // ret outranks call, so a simultaneous call never pushes.
`ifdef NEXT_PC_RAS_EN
          w_pop     = 1'b1;
          w_next_pc = w_cnt_zero ? w_pc_inc : w_ras_top;
`else
          w_next_pc = bus.target;
`endif
        end else if (bus.call) begin
`ifdef NEXT_PC_RAS_EN
          w_push    = 1'b1;
`endif
          w_next_pc = bus.target;
        end else if (bus.jump) begin
          w_next_pc = bus.target;
        end else if (bus.branch) begin
          w_next_pc = w_branch_tgt;
        end else begin
          w_next_pc = w_pc_inc;
        end
      end
      ST_HALT: begin
        w_next_pc = bus.pc;
        if (bus.resume && !bus.stall) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_next_pc   = RESET_PC;
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register; halted tracks the state being entered so it changes on
  // the same edge as the state itself.
  // --------------------------------------------------------------------------
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_BOOT;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_halted <= (w_state_nxt == ST_HALT);
    end
  end

  assign bus.next_pc = w_next_pc;
  assign bus.halted  = r_halted;

`ifdef NEXT_PC_RAS_EN
  // --------------------------------------------------------------------------
  // Return-address stack bookkeeping
  // --------------------------------------------------------------------------
  always_comb begin
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_count;
    w_err_set = 1'b0;
    if (w_push) begin
      w_ptr_nxt = r_ptr + PW'(1);
      if (w_cnt_full) begin
        w_err_set = 1'b1;          // oldest return address is lost
      end else begin
        w_cnt_nxt = r_count + CW'(1);
      end
    end else if (w_pop) begin
      if (w_cnt_zero) begin
        w_err_set = 1'b1;          // underflow: fall through to pc+1
      end else begin
        w_ptr_nxt = r_ptr - PW'(1);
        w_cnt_nxt = r_count - CW'(1);
      end
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_stack[i] <= '0;
      end
      r_ptr       <= '0;
      r_count     <= '0;
      r_ras_empty <= 1'b1;
      r_ras_full  <= 1'b0;
      r_ras_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_stack[r_ptr] <= w_pc_inc;
      end
      r_ptr       <= w_ptr_nxt;
      r_count     <= w_cnt_nxt;
      r_ras_empty <= (w_cnt_nxt == '0);
      r_ras_full  <= (w_cnt_nxt == C_CNT_FULL);
      r_ras_err   <= r_ras_err | w_err_set;
    end
  end

  assign bus.ras_empty = r_ras_empty;
  assign bus.ras_full  = r_ras_full;
  assign bus.ras_err   = r_ras_err;
`else
  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
  assign bus.ras_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_next_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_next_pc_unit
// Purpose  : Self-checking bench for next_pc_unit. A driver applies one
//            decision per cycle shortly after each falling edge and pushes
//            the reference model's expected outputs into a queue; a monitor
//            pops and compares on each rising edge. The model keeps its own
//            PC register image so the loop behaves like the real PC register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_next_pc_unit;
  localparam int          WIDTH     = 16;
  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam int          RAS_DEPTH = 4;

  logic clk = 1'b1;
  logic rst;
  always #5 clk = ~clk;

  next_pc_unit_if #(.WIDTH(WIDTH)) bus ();

  next_pc_unit #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] npc;
    logic        halted;
    logic        empty;
    logic        full;
    logic        err;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model state
  typedef enum {M_BOOT, M_RUN, M_HALT} mstate_t;
  mstate_t     m_state;
  logic [15:0] m_pc;
  logic [15:0] m_ras[$];
  logic        m_err;

  task automatic check(input string tag, input string name,
                       input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Computes the expected outputs for the inputs now on the bus, then
  // advances the model to its post-edge state.
  task automatic issue(input string tag);
    exp_t        e;
    logic [15:0] npc;
    logic [15:0] inc;
    inc   = bus.pc + 16'd1;
    e.tag = tag;
    if (rst) begin
      m_state = M_BOOT;
      m_ras.delete();
      m_err   = 1'b0;
    end
    e.halted = (m_state == M_HALT);
`ifdef NEXT_PC_RAS_EN
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == RAS_DEPTH);
    e.err   = m_err;
`else
    e.empty = 1'b1;
    e.full  = 1'b0;
    e.err   = 1'b0;
`endif
    npc = bus.pc;
    if (rst) begin
      npc = RESET_PC;
    end else if (m_state == M_BOOT) begin
      npc     = RESET_PC;
      m_state = M_RUN;
    end else if (m_state == M_HALT) begin
      npc = bus.pc;
      if (bus.resume && !bus.stall) m_state = M_RUN;
    end else begin
      if (bus.stall) begin
        npc = bus.pc;
      end else if (bus.halt_req) begin
        npc     = bus.pc;
        m_state = M_HALT;
      end else if (bus.ret) begin
`ifdef NEXT_PC_RAS_EN
        if (m_ras.size() == 0) begin
          npc   = inc;
          m_err = 1'b1;
        end else begin
          npc = m_ras.pop_back();
        end
`else
        npc = bus.target;
`endif
      end else if (bus.call) begin
`ifdef NEXT_PC_RAS_EN
        m_ras.push_back(inc);
        if (m_ras.size() > RAS_DEPTH) begin
          void'(m_ras.pop_front());
          m_err = 1'b1;
        end
`endif
        npc = bus.target;
      end else if (bus.jump) begin
        npc = bus.target;
      end else if (bus.branch) begin
        npc = inc + bus.branch_off;
      end else begin
        npc = inc;
      end
    end
    e.npc = npc;
    m_pc  = npc;
    exp_q.push_back(e);
  endtask

  // Opens a decision slot just after the falling edge with all requests
  // idle and pc taken from the modelled PC register.
  task automatic begin_cycle();
    @(negedge clk);
    #1;
    rst            = 1'b0;
    bus.stall      = 1'b0;
    bus.halt_req   = 1'b0;
    bus.resume     = 1'b0;
    bus.branch     = 1'b0;
    bus.jump       = 1'b0;
    bus.call       = 1'b0;
    bus.ret        = 1'b0;
    bus.branch_off = 16'($urandom);
    bus.target     = 16'($urandom);
    bus.pc         = m_pc;
  endtask

  task automatic plain(input string tag);
    begin_cycle();
    issue(tag);
  endtask

  // Monitor: one expected record per presented decision.
  always @(posedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, "next_pc",   bus.next_pc,            e.npc);
      check(e.tag, "halted",    {15'd0, bus.halted},    {15'd0, e.halted});
      check(e.tag, "ras_empty", {15'd0, bus.ras_empty}, {15'd0, e.empty});
      check(e.tag, "ras_full",  {15'd0, bus.ras_full},  {15'd0, e.full});
      check(e.tag, "ras_err",   {15'd0, bus.ras_err},   {15'd0, e.err});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    bus.pc         = 16'h0000;
    bus.stall      = 1'b0;
    bus.halt_req   = 1'b0;
    bus.resume     = 1'b0;
    bus.branch     = 1'b0;
    bus.branch_off = 16'h0000;
    bus.jump       = 1'b0;
    bus.target     = 16'h0000;
    bus.call       = 1'b0;
    bus.ret        = 1'b0;
    m_state        = M_BOOT;
    m_pc           = RESET_PC;
    m_err          = 1'b0;

    // Reset held, then released with the PC register looped back
    repeat (2) begin
      begin_cycle();
      rst = 1'b1;
      issue("reset");
    end
    begin_cycle(); bus.pc = 16'h0000; issue("boot");
    repeat (3) plain("seq");

    // Wrap and branches
    begin_cycle(); bus.pc = 16'hFFFF; issue("wrap");
    begin_cycle(); bus.pc = 16'h0010; bus.branch = 1'b1; bus.branch_off = 16'hFFFC; issue("br_neg");
    begin_cycle(); bus.pc = 16'h0010; bus.branch = 1'b1; bus.branch_off = 16'h0005; issue("br_pos");

    // Single call/return
    begin_cycle(); bus.pc = 16'h0020; bus.call = 1'b1; bus.target = 16'h0100; issue("call");
    plain("after_call");
    begin_cycle(); bus.ret = 1'b1; issue("ret");
    plain("after_ret");

    // Overflow then drain past empty
    for (int i = 0; i < 5; i++) begin
      begin_cycle();
      bus.pc     = 16'h0030 + 16'(i);
      bus.call   = 1'b1;
      bus.target = 16'h0200 + 16'(i);
      issue("call5");
    end
    plain("ras_full");
    for (int i = 0; i < 5; i++) begin
      begin_cycle(); bus.ret = 1'b1; issue("ret5");
    end
    plain("ras_drained");

    // ret and call together: no push
    begin_cycle(); bus.call = 1'b1; bus.ret = 1'b1; issue("call_ret");
    plain("call_ret_after");
    begin_cycle(); bus.ret = 1'b1; issue("call_ret_pop");

    // Halt, ignored requests while halted, stalled resume, resume
    begin_cycle(); bus.pc = 16'h0040; bus.halt_req = 1'b1; issue("halt");
    repeat (2) begin
      begin_cycle(); bus.jump = 1'b1; bus.call = 1'b1; bus.branch = 1'b1; issue("halted_jump");
    end
    begin_cycle(); bus.ret = 1'b1; issue("halted_ret");
    begin_cycle(); bus.resume = 1'b1; bus.stall = 1'b1; issue("resume_stalled");
    begin_cycle(); bus.resume = 1'b1; issue("resume");
    plain("resumed");

    // stall outranks halt_req
    begin_cycle(); bus.stall = 1'b1; bus.halt_req = 1'b1; issue("stall_halt");
    plain("stall_halt_after");

    // Asynchronous reset between edges with stack in use
    begin_cycle(); bus.call = 1'b1; issue("pre_rst_call");
    begin_cycle(); bus.call = 1'b1; issue("pre_rst_call");
    begin_cycle(); bus.call = 1'b1; rst = 1'b1; issue("rst_async");
    plain("rst_boot");
    plain("rst_run");
    begin_cycle(); bus.ret = 1'b1; issue("rst_ret");

    // Randomized decisions
    for (int n = 0; n < 400; n++) begin
      int r;
      begin_cycle();
      r            = int'($urandom_range(0, 99));
      bus.stall    = (r < 8);
      bus.halt_req = ($urandom_range(0, 99) < 5);
      bus.resume   = ($urandom_range(0, 99) < 30);
      bus.branch   = ($urandom_range(0, 99) < 25);
      bus.jump     = ($urandom_range(0, 99) < 10);
      bus.call     = ($urandom_range(0, 99) < 15);
      bus.ret      = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 99) < 10) bus.pc = 16'($urandom);
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      issue("rand");
    end

    @(posedge clk);
    #1;
    n_total++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end else begin
      n_pass++;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
